// File: rtl/uart_tx_mmio.sv
// ---------------------------------------------------------------------------
// uart_tx_mmio
//
// Purpose:
//   Memory-mapped UART transmitter. It responds on the processor data-memory
//   port beside data_mem. The top level gates data_mem's read data with ~hit.
//   Bytes written to TXDATA are queued in a TX FIFO. A serializer FSM shifts
//   them out on tx as 8N1 frames, or 8E1 frames when parity is enabled.
//
// Register window (16 bytes at BASE_ADDR, selected by addr[3:2]):
//   0x0 TXDATA  write pushes write_data[7:0]; reads 0
//   0x4 STATUS  bit0 full, bit1 empty, bit2 tx_busy,
//               bit3 overflow (sticky, write 1 clears), [15:8] count
//   0x8 CTRL    bit0 enable
//   0xC         reserved: reads 0, writes ignored
//
// Build option:
//   UART_TX_PARITY_EN - when defined, an even parity bit is inserted between
//                       the data bits and the stop bit (11-bit frame).
//
// Ports:
//   clk         clock, all state changes on the rising edge
//   rst         asynchronous, active-high reset
//   read_en     data-port load strobe
//   write_en    data-port store strobe
//   addr        byte address (addr[1:0] ignored)
//   write_data  store data
//   read_data   load data (combinational, 0 unless hit & read_en)
//   hit         address falls inside the register window
//   tx          serial output, idle high (registered)
//   tx_busy     serializer not idle (registered)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module uart_tx_mmio #(
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = ADDR_WIDTH'(32'h0000_1000),
  parameter int                    CLKS_PER_BIT = 16,
  parameter int                    FIFO_DEPTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  read_en,
  input  logic                  write_en,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  hit,
  output logic                  tx,
  output logic                  tx_busy
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  // Address decode
  logic [1:0] reg_sel;
  logic       wr_txdata;
  logic       wr_status;
  logic       wr_ctrl;

  // FIFO state
  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             fifo_full;
  logic             fifo_empty;
  logic [7:0]       fifo_head;
  logic             push;
  logic             push_drop;
  logic             pop;

  // Control / status
  logic ctrl_enable;
  logic overflow;

  // Serializer state
  state_t            state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        idx_q, idx_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              busy_q;
  logic              baud_done;
  logic              start_frame;
`ifdef UART_TX_PARITY_EN
  logic              parity_q, parity_d;
`endif

  // Address bits and data bits this peripheral never looks at
  logic unused_ok;
  assign unused_ok = &{1'b0, addr[1:0], write_data[DATA_WIDTH-1:8]};

  assign reg_sel   = addr[3:2];
  assign hit       = (addr[ADDR_WIDTH-1:4] == BASE_ADDR[ADDR_WIDTH-1:4]);
  assign wr_txdata = hit & write_en & (reg_sel == 2'd0);
  assign wr_status = hit & write_en & (reg_sel == 2'd1);
  assign wr_ctrl   = hit & write_en & (reg_sel == 2'd2);

  assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  assign fifo_head  = fifo_mem[rd_ptr];

  // A push into a full FIFO is dropped and flags overflow instead
  assign push      = wr_txdata & ~fifo_full;
  assign push_drop = wr_txdata & fifo_full;

  assign start_frame = ctrl_enable & ~fifo_empty;
  assign baud_done   = (baud_q == '0);

  // FIFO storage: data only, no reset needed since count gates validity
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= write_data[7:0];
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave count alone
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // CTRL enable and sticky overflow flag (write 1 to STATUS bit3 clears)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_enable <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        ctrl_enable <= write_data[0];
      end
      if (push_drop) begin
        overflow <= 1'b1;
      end else if (wr_status && write_data[3]) begin
        overflow <= 1'b0;
      end
    end
  end

  // Register read mux; only drives the bus on a load that hits the window
  always_comb begin
    read_data = '0;
    if (hit && read_en) begin
      case (reg_sel)
        2'd1: begin
          read_data[0]         = fifo_full;
          read_data[1]         = fifo_empty;
          read_data[2]         = busy_q;
          read_data[3]         = overflow;
          read_data[8 +: CNT_W] = count;
        end
        2'd2:    read_data[0] = ctrl_enable;
        default: read_data = '0;
      endcase
    end
  end

  // Serializer next-state logic. tx_d is the line level for the state being
  // entered, so tx is registered and changes on the same edge as the state.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif

    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (start_frame) begin
          pop     = 1'b1;
          shift_d = fifo_head;
`ifdef UART_TX_PARITY_EN
          parity_d = ^fifo_head;
`endif
          baud_d  = BAUD_MAX;
          state_d = START;
          tx_d    = 1'b0;
        end
      end

      START: begin
        if (baud_done) begin
          baud_d  = BAUD_MAX;
          idx_d   = 3'd0;
          state_d = DATA;
          tx_d    = shift_q[0];
        end else begin
          baud_d = baud_q - BAUD_W'(1);
        end
      end

      // The shift register drops one bit per bit time so bit0 is always
      // the bit on the line.
      DATA: begin
        if (baud_done) begin
          baud_d = BAUD_MAX;
          if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = parity_q;
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            idx_d   = idx_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q - BAUD_W'(1);
        end
      end

`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baud_done) begin
          baud_d  = BAUD_MAX;
          state_d = STOP;
          tx_d    = 1'b1;
        end else begin
          baud_d = baud_q - BAUD_W'(1);
        end
      end
`endif

      // End of stop bit chains straight into the next start bit when more
      // data is waiting, so back-to-back bytes have no idle gap.
      STOP: begin
        if (baud_done) begin
          if (start_frame) begin
            pop     = 1'b1;
            shift_d = fifo_head;
`ifdef UART_TX_PARITY_EN
            parity_d = ^fifo_head;
`endif
            baud_d  = BAUD_MAX;
            state_d = START;
            tx_d    = 1'b0;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          baud_d = baud_q - BAUD_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // Serializer registers; reset forces the line idle immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= (state_d != IDLE);
    end
  end

`ifdef UART_TX_PARITY_EN
  // Parity of the byte in flight, captured when it is popped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end
`endif

  assign tx      = tx_q;
  assign tx_busy = busy_q;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_mmio
//
// Self-checking bench for uart_tx_mmio with CLKS_PER_BIT=4, FIFO_DEPTH=8,
// BASE_ADDR=0x1000. Register accesses come from a table of directed vectors.
// Serial waveforms are compared cycle by cycle against frames built by the
// bench from the byte values.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_uart_tx_mmio;

  localparam int CPB = 4;

  logic        clk;
  logic        rst;
  logic        read_en;
  logic        write_en;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        hit;
  logic        tx;
  logic        tx_busy;

  int checks = 0;
  int errors = 0;

  // mode: 0 = write, 1 = read with read_en, 2 = read_en low
  typedef struct {
    int          mode;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_hit;
  } vec_t;

  vec_t vecs[$];

  logic exp_wave [0:511];
  int   exp_len = 0;

  uart_tx_mmio #(
    .ADDR_WIDTH  (32),
    .DATA_WIDTH  (32),
    .BASE_ADDR   (32'h0000_1000),
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .read_en   (read_en),
    .write_en  (write_en),
    .addr      (addr),
    .write_data(write_data),
    .read_data (read_data),
    .hit       (hit),
    .tx        (tx),
    .tx_busy   (tx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  // Starts and ends on a falling edge; writes act at the rising edge between
  task automatic applyStimulus(input vec_t v, input string name);
    addr = v.addr;
    if (v.mode == 0) begin
      write_data = v.wdata;
      write_en   = 1'b1;
      @(negedge clk);
      write_en   = 1'b0;
    end else begin
      read_en = (v.mode == 1);
      #1;
      checkOutput({name, "_rdata"}, read_data, v.exp_rd);
      checkOutput({name, "_hit"}, 32'(hit), 32'(v.exp_hit));
      @(negedge clk);
      read_en = 1'b0;
    end
  endtask

  task automatic busWrite(input logic [31:0] a, input logic [31:0] d);
    vec_t v;
    v = '{0, a, d, 32'h0, 1'b1};
    applyStimulus(v, "wr");
  endtask

  task automatic busRead(input logic [31:0] a, input logic [31:0] exp,
                         input string name);
    vec_t v;
    v = '{1, a, 32'h0, exp, 1'b1};
    applyStimulus(v, name);
  endtask

  // Appends one frame: start, 8 data bits LSB first, [parity], stop
  task automatic addFrame(input logic [7:0] b);
    logic [10:0] bits;
    int          nbits;
`ifdef UART_TX_PARITY_EN
    bits  = {1'b1, ^b, b, 1'b0};
    nbits = 11;
`else
    bits  = {1'b0, 1'b1, b, 1'b0};
    nbits = 10;
`endif
    for (int i = 0; i < nbits; i++) begin
      for (int k = 0; k < CPB; k++) begin
        exp_wave[exp_len] = bits[i];
        exp_len++;
      end
    end
  endtask

  // Called at the falling edge that lies inside the first start-bit cycle
  task automatic checkWave(input string name);
    int bad;
    int first_bad;
    logic got_tx;
    logic got_busy;
    bad       = 0;
    first_bad = -1;
    for (int c = 0; c < exp_len; c++) begin
      got_tx   = tx;
      got_busy = tx_busy;
      if (got_tx !== exp_wave[c] || got_busy !== 1'b1) begin
        if (first_bad < 0) begin
          first_bad = c;
          $display("[TB] %s first bad cycle %0d tx=%b exp=%b busy=%b",
                   name, c, got_tx, exp_wave[c], got_busy);
        end
        bad++;
      end
      @(negedge clk);
    end
    checkOutput({name, "_bad_cycles"}, 32'(bad), 32'd0);
    checkOutput({name, "_end_busy"}, 32'(tx_busy), 32'd0);
    checkOutput({name, "_end_tx"}, 32'(tx), 32'd1);
    exp_len = 0;
  endtask

  task automatic checkIdle(input string name, input int n);
    int bad;
    bad = 0;
    for (int c = 0; c < n; c++) begin
      if (tx !== 1'b1 || tx_busy !== 1'b0) bad++;
      @(negedge clk);
    end
    checkOutput({name, "_idle_bad"}, 32'(bad), 32'd0);
  endtask

  task automatic waitNotBusy(input string name, input int bound);
    int n;
    n = 0;
    while (tx_busy && n < bound) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, "_timeout"}, 32'(n >= bound), 32'd0);
  endtask

  initial begin
    rst        = 1'b1;
    read_en    = 1'b0;
    write_en   = 1'b0;
    addr       = 32'h0;
    write_data = 32'h0;

    // Register-level vectors: reset state, decode, CTRL, overflow handling
    vecs.push_back('{1, 32'h1004, 32'h0, 32'h0000_0002, 1'b1});
    vecs.push_back('{1, 32'h1008, 32'h0, 32'h0000_0000, 1'b1});
    vecs.push_back('{1, 32'h1000, 32'h0, 32'h0000_0000, 1'b1});
    vecs.push_back('{1, 32'h100C, 32'h0, 32'h0000_0000, 1'b1});
    vecs.push_back('{0, 32'h2000, 32'h11, 32'h0, 1'b0});
    vecs.push_back('{1, 32'h2000, 32'h0, 32'h0000_0000, 1'b0});
    vecs.push_back('{1, 32'h1004, 32'h0, 32'h0000_0002, 1'b1});
    vecs.push_back('{2, 32'h1004, 32'h0, 32'h0000_0000, 1'b1});
    vecs.push_back('{0, 32'h100C, 32'hFFFF_FFFF, 32'h0, 1'b1});
    vecs.push_back('{1, 32'h1004, 32'h0, 32'h0000_0002, 1'b1});
    vecs.push_back('{0, 32'h1008, 32'hFFFF_FFFE, 32'h0, 1'b1});
    vecs.push_back('{1, 32'h1008, 32'h0, 32'h0000_0000, 1'b1});
    vecs.push_back('{0, 32'h1008, 32'h0000_0003, 32'h0, 1'b1});
    vecs.push_back('{1, 32'h1009, 32'h0, 32'h0000_0001, 1'b1});
    vecs.push_back('{0, 32'h1008, 32'h0, 32'h0, 1'b1});
    for (int i = 1; i <= 9; i++) begin
      vecs.push_back('{0, 32'h1000, 32'(i), 32'h0, 1'b1});
    end
    vecs.push_back('{1, 32'h1004, 32'h0, 32'h0000_0809, 1'b1});
    vecs.push_back('{0, 32'h1004, 32'h0000_0007, 32'h0, 1'b1});
    vecs.push_back('{1, 32'h1004, 32'h0, 32'h0000_0809, 1'b1});
    vecs.push_back('{0, 32'h1004, 32'h0000_0008, 32'h0, 1'b1});
    vecs.push_back('{1, 32'h1006, 32'h0, 32'h0000_0801, 1'b1});
    vecs.push_back('{0, 32'h2000, 32'h77, 32'h0, 1'b0});
    vecs.push_back('{1, 32'h1004, 32'h0, 32'h0000_0801, 1'b1});

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rst_tx", 32'(tx), 32'd1);
    checkOutput("rst_busy", 32'(tx_busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
    end

    // Enable drains the eight queued bytes; the dropped 0x09 never appears
    busWrite(32'h1008, 32'h1);
    @(negedge clk);
    for (int i = 1; i <= 8; i++) addFrame(8'(i));
    checkWave("drain8");
    busRead(32'h1004, 32'h0000_0002, "drain_status");

    // Single byte: tx falls one edge after the push edge, no fall-through
    busWrite(32'h1000, 32'hA5);
    checkOutput("a5_pre_tx", 32'(tx), 32'd1);
    checkOutput("a5_pre_busy", 32'(tx_busy), 32'd0);
    @(negedge clk);
    addFrame(8'hA5);
    checkWave("byte_a5");

    // Back-to-back: second start bit directly follows the first stop bit
    busWrite(32'h1000, 32'h55);
    busWrite(32'h1000, 32'hAA);
    addFrame(8'h55);
    addFrame(8'hAA);
    checkWave("b2b");

    // Clearing enable mid-frame: current frame finishes, next one waits
    busWrite(32'h1000, 32'h5A);
    busWrite(32'h1000, 32'h3C);
    repeat (10) @(negedge clk);
    busWrite(32'h1008, 32'h0);
    waitNotBusy("disable", 100);
    checkIdle("disable", 20);
    busRead(32'h1004, 32'h0000_0100, "disable_status");

    // Async reset during DATA (0x3C bit0 is low) flushes FIFO and idles tx
    busWrite(32'h1000, 32'h44);
    busWrite(32'h1008, 32'h1);
    repeat (8) @(negedge clk);
    checkOutput("mid_tx_low", 32'(tx), 32'd0);
    rst = 1'b1;
    #1;
    checkOutput("arst_tx", 32'(tx), 32'd1);
    checkOutput("arst_busy", 32'(tx_busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    busRead(32'h1004, 32'h0000_0002, "arst_status");
    busRead(32'h1008, 32'h0000_0000, "arst_ctrl");
    checkIdle("arst", 20);

`ifdef UART_TX_PARITY_EN
    // Parity build: 0x07 has odd weight, parity bit 1, 44-cycle frame
    busWrite(32'h1008, 32'h1);
    busWrite(32'h1000, 32'h07);
    @(negedge clk);
    addFrame(8'h07);
    checkOutput("parity_len", 32'(exp_len), 32'd44);
    checkWave("parity_07");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
